sha256_msg_padder: RTL and testbench

Multi-block message front end for the SHA256 accelerator. It reads message bytes from the byte-wide message SRAM and emits SHA256-padded 512-bit blocks. Each block leaves as sixteen big-endian 32-bit words over a valid/ready stream to the message scheduler/compression core. It replaces the single-block (≤55-byte) message path, supports any length up to `MAX_MESSAGE_LENGTH`, and produces 1..N blocks with correct FIPS 180-4 padding and length field.

---
 rtl/sha256_pad_pkg.sv | 52 +++++
 rtl/sha256_pad_word_asm.sv | 30 +++
 rtl/sha256_msg_padder.sv | 168 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pad_pkg.sv
// Shared types, sizes and the padded-byte rule for the SHA256 message padder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha256_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } pad_state_t;

  localparam int WORD_W          = 32;
  localparam int BLOCK_WORDS     = 16;
  localparam int BLOCK_BYTES     = 64;
  localparam int LEN_FIELD_BYTES = 8;

  // Five FETCH cycles per word: four byte slots plus one drain slot for the
  // last SRAM read to land in the assembler.
  localparam int FETCH_SLOTS = 5;

  // Block counter width; the stream byte index is {block, word, byte}.
  // Six bits cover up to 63 blocks, far beyond the default message size.
  localparam int BLK_W = 6;
  localparam int IDX_W = BLK_W + 6;

  // Byte i of the padded stream for a message of len bytes spread over nblk
  // blocks. sram_byte is used only when i falls inside the message.
  function automatic logic [7:0] pad_byte(
    input logic [IDX_W-1:0] i,
    input logic [IDX_W-1:0] len,
    input logic [BLK_W-1:0] nblk,
    input logic [7:0]       sram_byte
  );
    logic [IDX_W-1:0] len_field_start;
    logic [63:0]      bit_len;
    len_field_start = IDX_W'(int'(nblk) * BLOCK_BYTES - LEN_FIELD_BYTES);
    bit_len         = {{(64-IDX_W-3){1'b0}}, len, 3'b000};
    if (i < len) begin
      pad_byte = sram_byte;
    end else if (i == len) begin
      pad_byte = 8'h80;
    end else if (i >= len_field_start) begin
      // The length field starts 8-byte aligned, so i[2:0] is the byte
      // position inside the big-endian 64-bit bit count.
      pad_byte = 8'(bit_len >> {3'd7 - i[2:0], 3'b000});
    end else begin
      pad_byte = 8'h00;
    end
  endfunction

endpackage

// File: rtl/sha256_pad_word_asm.sv
// 4-byte shift assembler: bytes enter at the LSB so the first byte ends in [31:24].
// Latency: one cycle per loaded byte; word complete after four loads.
// Backpressure: none; holds its value whenever load and clear are low.
import sha256_pad_pkg::*;

module sha256_pad_word_asm (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] r_word;

  // Shift the new byte in from the bottom; clear takes priority over load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
    end else if (i_clear) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= {r_word[WORD_W-9:0], i_byte};
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a message from byte SRAM and emits SHA256-padded blocks as 16 big-endian words.
// Latency: first word valid 5 cycles after go is taken; each later word 5 cycles after the previous transfer.
// Backpressure: valid/ready; while stalled the word and flags hold and no SRAM reads are issued.
import sha256_pad_pkg::*;

module sha256_msg_padder #(
  parameter  int MAX_MESSAGE_LENGTH = 247,
  parameter  int SYMBOL_WIDTH       = 8,
  localparam int LEN_W              = $clog2(MAX_MESSAGE_LENGTH + 1),
  localparam int ADDR_W             = $clog2(MAX_MESSAGE_LENGTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    xxx__pad__go,
  input  logic [LEN_W-1:0]        xxx__pad__msg_length,
  output logic                    pad__xxx__finish,
  output logic [ADDR_W-1:0]       pad__msg__address,
  output logic                    pad__msg__enable,
  output logic                    pad__msg__write,
  input  logic [SYMBOL_WIDTH-1:0] msg__pad__data,
  output logic [WORD_W-1:0]       pad__sch__word,
  output logic                    pad__sch__valid,
  input  logic                    sch__pad__ready,
  output logic [3:0]              pad__sch__word_index,
  output logic                    pad__sch__first,
  output logic                    pad__sch__last
);

  pad_state_t r_state;
  pad_state_t w_state_nxt;

  logic [IDX_W-1:0] r_len;
  logic [BLK_W-1:0] r_nblk;
  logic [BLK_W-1:0] r_blk;
  logic [3:0]       r_word;
  logic [2:0]       r_slot;

  logic [IDX_W-1:0] w_len_in;
  logic [IDX_W-1:0] w_len_clamp;
  logic [IDX_W-1:0] w_len_plus;
  logic [BLK_W-1:0] w_nblk_in;
  logic             w_go_take;
  logic             w_in_fetch;
  logic             w_slot_last;
  logic             w_xfer;
  logic             w_word_last;
  logic             w_stream_last;
  logic [1:0]       w_prev_slot;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_prev_idx;
  logic             w_rd_en;
  logic             w_asm_load;
  logic [7:0]       w_asm_byte;
  logic [WORD_W-1:0] w_asm_word;

  // Length clamp and block count for the run being started: N = (L+8)/64 + 1.
  always_comb begin
    w_len_in    = IDX_W'(xxx__pad__msg_length);
    w_len_clamp = w_len_in;
    if (w_len_in > IDX_W'(MAX_MESSAGE_LENGTH)) begin
      w_len_clamp = IDX_W'(MAX_MESSAGE_LENGTH);
    end
    w_len_plus = w_len_clamp + IDX_W'(LEN_FIELD_BYTES);
    w_nblk_in  = BLK_W'(w_len_plus >> 6) + BLK_W'(1);
  end

  assign w_go_take     = (r_state == ST_IDLE) && xxx__pad__go;
  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_slot_last   = (r_slot == 3'(FETCH_SLOTS - 1));
  assign w_xfer        = (r_state == ST_PRESENT) && sch__pad__ready;
  assign w_word_last   = (r_word == 4'(BLOCK_WORDS - 1));
  assign w_stream_last = w_word_last && (r_blk == (r_nblk - BLK_W'(1)));

  // Slot c reads byte c of the current word; the byte read in the previous
  // slot is the one being shifted in (slot 4 wraps back to byte 3).
  assign w_prev_slot = r_slot[1:0] - 2'd1;
  assign w_fetch_idx = {r_blk, r_word, r_slot[1:0]};
  assign w_prev_idx  = {r_blk, r_word, w_prev_slot};

  assign w_rd_en    = w_in_fetch && !w_slot_last && (w_fetch_idx < r_len);
  assign w_asm_load = w_in_fetch && (r_slot != 3'd0);
  assign w_asm_byte = pad_byte(w_prev_idx, r_len, r_nblk, msg__pad__data[7:0]);

  // Run state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: go only matters in IDLE, so a held go cannot restart a run mid-way.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (xxx__pad__go) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_slot_last) begin
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (sch__pad__ready) begin
          w_state_nxt = w_stream_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run parameters, fetch slot, and word/block position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len  <= '0;
      r_nblk <= '0;
      r_blk  <= '0;
      r_word <= '0;
      r_slot <= '0;
    end else begin
      if (w_go_take) begin
        r_len  <= w_len_clamp;
        r_nblk <= w_nblk_in;
        r_blk  <= '0;
        r_word <= '0;
        r_slot <= '0;
      end
      if (w_in_fetch) begin
        r_slot <= w_slot_last ? 3'd0 : r_slot + 3'd1;
      end
      if (w_xfer) begin
        r_word <= r_word + 4'd1;
        if (w_word_last) begin
          r_blk <= r_blk + BLK_W'(1);
        end
      end
    end
  end

  sha256_pad_word_asm u_word_asm (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_go_take),
    .i_load  (w_asm_load),
    .i_byte  (w_asm_byte),
    .o_word  (w_asm_word)
  );

  assign pad__msg__enable     = w_rd_en;
  assign pad__msg__address    = w_rd_en ? w_fetch_idx[ADDR_W-1:0] : '0;
  assign pad__msg__write      = 1'b0;
  assign pad__sch__word       = w_asm_word;
  assign pad__sch__valid      = (r_state == ST_PRESENT);
  assign pad__sch__word_index = r_word;
  assign pad__sch__first      = pad__sch__valid && (r_blk == '0) && (r_word == 4'd0);
  assign pad__sch__last       = pad__sch__valid && w_stream_last;
  assign pad__xxx__finish     = (r_state == ST_DONE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of message lengths plus stall/reset/held-go sequences.
// Latency: checks 5-cycle fetch spacing and the finish pulse after the last word.
// Backpressure: drives ready low for a stretch and checks the held word.
module tb_sha256_msg_padder;

  localparam int MAXL = 247;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  msg_len;
  logic        finish;
  logic [7:0]  address;
  logic        enable;
  logic        write;
  logic [7:0]  rd_data = 8'h00;
  logic [31:0] word;
  logic        valid;
  logic        ready;
  logic [3:0]  word_index;
  logic        first;
  logic        last;

  logic [7:0] mem [0:MAXL-1];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        first;
    logic        last;
  } exp_t;

  exp_t exp_q [$];

  typedef struct {
    int          len;
    int          blocks;
    int          spot_pos;
    logic [31:0] spot_word;
    logic [31:0] final_word;
  } vec_t;

  vec_t vecs [6];
  vec_t v100;

  sha256_msg_padder dut (
    .clk                  (clk),
    .reset                (reset),
    .xxx__pad__go         (go),
    .xxx__pad__msg_length (msg_len),
    .pad__xxx__finish     (finish),
    .pad__msg__address    (address),
    .pad__msg__enable     (enable),
    .pad__msg__write      (write),
    .msg__pad__data       (rd_data),
    .pad__sch__word       (word),
    .pad__sch__valid      (valid),
    .sch__pad__ready      (ready),
    .pad__sch__word_index (word_index),
    .pad__sch__first      (first),
    .pad__sch__last       (last)
  );

  always #5 clk = ~clk;

  // Byte-wide message SRAM with one cycle read latency.
  always @(posedge clk) begin
    if (enable) begin
      if (address < 8'(MAXL)) rd_data <= mem[address];
      else                    rd_data <= 8'h00;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Padded stream byte from the FIPS 180-4 rule.
  function automatic logic [7:0] model_byte(input int i, input int lc, input int nb);
    longint bits;
    int     sh;
    if (i < lc) return mem[i];
    if (i == lc) return 8'h80;
    if (i >= 64 * nb - 8) begin
      bits = longint'(lc) * 8;
      sh   = 8 * (64 * nb - 1 - i);
      return 8'((bits >> sh) & 64'hff);
    end
    return 8'h00;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_finish"}, 64'(finish), 0);
    chk({tag, "_enable"}, 64'(enable), 0);
    chk({tag, "_write"},  64'(write), 0);
    chk({tag, "_valid"},  64'(valid), 0);
    chk({tag, "_first"},  64'(first), 0);
    chk({tag, "_last"},   64'(last), 0);
    chk({tag, "_word"},   64'(word), 0);
    chk({tag, "_index"},  64'(word_index), 0);
    chk({tag, "_addr"},   64'(address), 0);
  endtask

  // One message run: push expected words, drive go, then follow the stream.
  task automatic run_msg(input vec_t v, input int hold_word, input int reset_word, input int go_hold);
    int   lc, nb, cyc, widx, gap, en_cnt, go_left, budget;
    bit   exp_fin, done, aborted;
    exp_t e;
    lc = (v.len > MAXL) ? MAXL : v.len;
    nb = (lc + 8) / 64 + 1;
    for (int k = 0; k < 16 * nb; k++) begin
      e.w     = {model_byte(4*k, lc, nb), model_byte(4*k+1, lc, nb),
                 model_byte(4*k+2, lc, nb), model_byte(4*k+3, lc, nb)};
      e.idx   = 4'(k % 16);
      e.first = (k == 0);
      e.last  = (k == 16 * nb - 1);
      exp_q.push_back(e);
    end
    cyc = 0; widx = 0; gap = 0; en_cnt = 0;
    exp_fin = 0; done = 0; aborted = 0;
    go_left = go_hold;
    budget  = 16 * nb * 6 + 60;
    @(negedge clk);
    msg_len = 8'(v.len);
    go      = 1'b1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      go_left--;
      if (go_left <= 0) go = 1'b0;
      if (enable) en_cnt++;
      if (exp_fin) begin
        chk("finish_pulse", 64'(finish), 1);
        chk("valid_at_finish", 64'(valid), 0);
        @(negedge clk);
        chk("finish_width", 64'(finish), 0);
        done = 1;
      end else if (valid) begin
        chk("finish_early", 64'(finish), 0);
        if (widx == 0) chk("first_latency", 64'(cyc), 6);
        else           chk("word_gap", 64'(gap), 5);
        if (widx == reset_word) begin
          reset = 1'b0;
          #1;
          check_reset_outputs("midrun_reset");
          @(negedge clk);
          reset = 1'b1;
          ready = 1'b1;
          exp_q.delete();
          aborted = 1;
          done    = 1;
        end else begin
          if (widx == hold_word) begin
            ready = 1'b0;
            for (int s = 0; s < 10; s++) begin
              @(negedge clk);
              cyc++;
              chk("stall_valid", 64'(valid), 1);
              chk("stall_word", 64'(word), 64'(exp_q[0].w));
              chk("stall_index", 64'(word_index), 64'(exp_q[0].idx));
              chk("stall_no_read", 64'(enable), 0);
            end
            ready = 1'b1;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(word), 64'hdead);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'(word), 64'(e.w));
            chk("word_index", 64'(word_index), 64'(e.idx));
            chk("first", 64'(first), 64'(e.first));
            chk("last", 64'(last), 64'(e.last));
            if (widx == v.spot_pos) chk("spot_word", 64'(word), 64'(v.spot_word));
            if (e.last) chk("final_word", 64'(word), 64'(v.final_word));
            widx++;
            gap = 0;
            if (exp_q.size() == 0) exp_fin = 1;
          end
        end
      end else begin
        chk("finish_idle", 64'(finish), 0);
        gap++;
      end
    end
    chk("run_complete", 64'(done), 1);
    if (!aborted) begin
      chk("word_count", 64'(widx), 64'(16 * v.blocks));
      chk("sram_reads", 64'(en_cnt), 64'(lc));
    end
    exp_q.delete();
    go = 1'b0;
  endtask

  initial begin
    int idle_activity;
    for (int i = 0; i < MAXL; i++) mem[i] = 8'(8'h61 + i);

    // len, blocks, spot word position, spot word, final word
    vecs[0] = '{5,   1, 1,  32'h65800000, 32'h00000028};
    vecs[1] = '{55,  1, 13, 32'h95969780, 32'h000001B8};
    vecs[2] = '{56,  2, 14, 32'h80000000, 32'h000001C0};
    vecs[3] = '{0,   1, 0,  32'h80000000, 32'h00000000};
    vecs[4] = '{64,  2, 16, 32'h80000000, 32'h00000200};
    vecs[5] = '{255, 4, 61, 32'h55565780, 32'h000007B8};
    v100    = '{100, 2, 25, 32'h80000000, 32'h00000320};

    reset   = 1'b1;
    go      = 1'b0;
    ready   = 1'b1;
    msg_len = 8'd0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_msg(vecs[i], -1, -1, 1);

    // Stall at word 3 for ten cycles.
    run_msg(v100, 3, -1, 1);

    // Reset pulse at block 1 word 7, then a clean L=5 run.
    run_msg(v100, -1, 23, 1);
    run_msg(vecs[0], -1, -1, 1);

    // Go held for ten cycles produces a single run.
    run_msg(vecs[0], -1, -1, 10);
    idle_activity = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      if (valid || enable || finish) idle_activity++;
    end
    chk("single_run", 64'(idle_activity), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
